accum_frame_scheduler: RTL and testbench

- Controller that periodically or on demand snapshots the 24-bit event accumulator value.
- Packs the snapshot into a 5-byte frame and sequences it byte-by-byte into the UART transmitter using a start/done handshake.
- Sits between the accumulator datapath and uart_tx. It owns the sampling cadence, frame format, overrun reporting and TX stall recovery.

---
 rtl/accum_frame_scheduler.sv | 133 +++++++++++++
 tb/tb_accum_frame_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_frame_scheduler.sv
// Snapshots the 24-bit accumulator periodically or on request and streams it
// to uart_tx as a 5-byte frame: header, three value bytes, XOR checksum.
module accum_frame_scheduler #(
  parameter logic [23:0] PERIOD  = 24'd50000,
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd60000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        En,
  input  logic        Trig_In,
  input  logic        Ovr_Clr,
  input  logic [23:0] Acc_Value,
  input  logic        Tx_Busy,
  input  logic        Tx_Done,
  output logic        Tx_Start,
  output logic [7:0]  Tx_Data,
  output logic        Frame_Busy,
  output logic [7:0]  Frame_Cnt,
  output logic        Overrun,
  output logic        Err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state;
  logic [23:0] period_cnt;
  logic [15:0] tout_cnt;
  logic [2:0]  idx;
  logic [23:0] snap;
  logic        tick;
  logic        trig;

  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [23:0] s);
    logic [7:0] b;
    case (i)
      3'd1:    b = s[23:16];
      3'd2:    b = s[15:8];
      3'd3:    b = s[7:0];
      3'd4:    b = HEADER ^ s[23:16] ^ s[15:8] ^ s[7:0];
      default: b = HEADER;
    endcase
    return b;
  endfunction

  assign tick       = En && (period_cnt == PERIOD - 24'd1);
  assign trig       = tick | Trig_In;
  // Start is combinational so a byte launches in the very cycle Tx_Busy drops.
  assign Tx_Start   = (state == ISSUE) && !Tx_Busy;
  assign Frame_Busy = (state != IDLE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      period_cnt <= '0;
    end else if (!En || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + 24'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      tout_cnt  <= '0;
      idx       <= '0;
      snap      <= '0;
      Tx_Data   <= '0;
      Frame_Cnt <= '0;
      Overrun   <= 1'b0;
      Err       <= 1'b0;
    end else begin
      // Clear first; any set below in the same cycle overrides it.
      if (Ovr_Clr) begin
        Overrun <= 1'b0;
        Err     <= 1'b0;
      end
      if (trig && state != IDLE) begin
        Overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (trig) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          snap    <= Acc_Value;
          idx     <= '0;
          Tx_Data <= HEADER;
          state   <= ISSUE;
        end
        ISSUE: begin
          if (!Tx_Busy) begin
            tout_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (Tx_Done) begin
            if (idx == 3'd4) begin
              state <= DONE;
            end else begin
              idx     <= idx + 3'd1;
              Tx_Data <= frame_byte(idx + 3'd1, snap);
              state   <= ISSUE;
            end
          end else if (tout_cnt == TIMEOUT - 16'd1) begin
            Err   <= 1'b1;
            state <= IDLE;
          end else begin
            tout_cnt <= tout_cnt + 16'd1;
          end
        end
        DONE: begin
          Frame_Cnt <= Frame_Cnt + 8'd1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_frame_scheduler.sv
// Scoreboard bench for accum_frame_scheduler: expected frame bytes are queued
// by the stimulus, and a monitor pops one on every Tx_Start.
module tb_accum_frame_scheduler;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        En;
  logic        Trig_In;
  logic        Ovr_Clr;
  logic [23:0] Acc_Value;
  logic        Tx_Busy;
  logic        Tx_Done;
  logic        Tx_Start;
  logic [7:0]  Tx_Data;
  logic        Frame_Busy;
  logic [7:0]  Frame_Cnt;
  logic        Overrun;
  logic        Err;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];

  // UART model controls
  logic        ubusy = 1'b0;
  logic        udone = 1'b0;
  logic        force_busy = 1'b0;
  logic        never_done = 1'b0;
  int          dly = 3;
  int          ucnt = 0;

  assign Tx_Busy = ubusy | force_busy;
  assign Tx_Done = udone;

  accum_frame_scheduler #(
    .PERIOD(24'd16),
    .HEADER(8'hA5),
    .TIMEOUT(16'd8)
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .En(En),
    .Trig_In(Trig_In),
    .Ovr_Clr(Ovr_Clr),
    .Acc_Value(Acc_Value),
    .Tx_Busy(Tx_Busy),
    .Tx_Done(Tx_Done),
    .Tx_Start(Tx_Start),
    .Tx_Data(Tx_Data),
    .Frame_Busy(Frame_Busy),
    .Frame_Cnt(Frame_Cnt),
    .Overrun(Overrun),
    .Err(Err)
  );

  always #5 CLK = ~CLK;

  // UART model: Tx_Done pulses dly cycles after the Tx_Start cycle.
  initial begin
    forever begin
      @(negedge CLK);
      udone = 1'b0;
      if (ucnt > 0) begin
        ucnt = ucnt - 1;
        if (ucnt == 0) begin
          udone = !never_done;
          ubusy = 1'b0;
        end else begin
          ubusy = 1'b1;
        end
      end
      #2;
      if (Tx_Start) ucnt = dly;
    end
  end

  // Monitor: every Tx_Start must carry the next queued byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLK);
      #1;
      if (Tx_Start) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tx_start: data %02h with nothing expected", Tx_Data);
        end else begin
          e = exp_q.pop_front();
          if (Tx_Data !== e) begin
            errors++;
            $display("FAIL tx_byte: got %02h expected %02h", Tx_Data, e);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [23:0] v);
    exp_q.push_back(8'hA5);
    exp_q.push_back(v[23:16]);
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
    exp_q.push_back(8'hA5 ^ v[23:16] ^ v[15:8] ^ v[7:0]);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic pulse_trig();
    Trig_In = 1'b1;
    @(negedge CLK);
    Trig_In = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (Frame_Busy && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (Frame_Busy) begin
      errors++;
      $display("FAIL frame_end_timeout: still busy after %0d cycles", maxc);
    end
  endtask

  task automatic run_frame(input logic [23:0] v);
    push_frame(v);
    Acc_Value = v;
    pulse_trig();
    wait_idle(200);
  endtask

  initial begin
    RSTn = 1'b0; En = 1'b0; Trig_In = 1'b0; Ovr_Clr = 1'b0; Acc_Value = '0;
    @(negedge CLK);
    #1;
    check("rst_tx_start", Tx_Start, 0);
    check("rst_tx_data", Tx_Data, 0);
    check("rst_frame_busy", Frame_Busy, 0);
    check("rst_frame_cnt", Frame_Cnt, 0);
    check("rst_overrun", Overrun, 0);
    check("rst_err", Err, 0);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);

    // Manual trigger, latency of two cycles to the first Tx_Start
    dly = 3;
    Acc_Value = 24'h123456;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'hD5);
    pulse_trig();
    #1;
    check("lat_k1_no_start", Tx_Start, 0);
    check("lat_k1_busy", Frame_Busy, 1);
    @(negedge CLK);
    #1;
    check("lat_k2_start", Tx_Start, 1);
    check("lat_k2_data", Tx_Data, 8'hA5);
    wait_idle(200);
    check("t1_frame_cnt", Frame_Cnt, 1);
    check("t1_queue_empty", exp_q.size(), 0);

    // Periodic ticks every 16 cycles
    dly = 1;
    Acc_Value = 24'h000000;
    push_frame(24'h0); push_frame(24'h0); push_frame(24'h0);
    @(negedge CLK);
    En = 1'b1;
    repeat (30) @(negedge CLK);
    check("per_cnt_1", Frame_Cnt, 2);
    repeat (16) @(negedge CLK);
    check("per_cnt_2", Frame_Cnt, 3);
    repeat (2) @(negedge CLK);
    En = 1'b0;
    repeat (14) @(negedge CLK);
    check("per_cnt_3", Frame_Cnt, 4);
    repeat (20) @(negedge CLK);
    check("per_stopped", Frame_Cnt, 4);
    check("per_no_overrun", Overrun, 0);
    check("per_queue_empty", exp_q.size(), 0);

    // Tx_Busy stall; Acc_Value change mid-frame must not leak into the frame
    dly = 3;
    Acc_Value = 24'hABCDEF;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hAB); exp_q.push_back(8'hCD);
    exp_q.push_back(8'hEF); exp_q.push_back(8'h2C);
    force_busy = 1'b1;
    pulse_trig();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i == 3) Acc_Value = 24'hFFFFFF;
      #1;
      check("stall_no_start", Tx_Start, 0);
    end
    @(negedge CLK);
    force_busy = 1'b0;
    #1;
    check("stall_release_start", Tx_Start, 1);
    wait_idle(200);
    check("stall_frame_cnt", Frame_Cnt, 5);
    check("stall_queue_empty", exp_q.size(), 0);

    // Overrun on a dropped trigger
    Acc_Value = 24'h000102;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h01);
    exp_q.push_back(8'h02); exp_q.push_back(8'hA6);
    pulse_trig();
    repeat (5) @(negedge CLK);
    pulse_trig();
    check("ovr_set", Overrun, 1);
    wait_idle(200);
    check("ovr_single_frame", Frame_Cnt, 6);
    Ovr_Clr = 1'b1;
    @(negedge CLK);
    Ovr_Clr = 1'b0;
    check("ovr_clear", Overrun, 0);
    push_frame(24'h000102);
    pulse_trig();
    repeat (4) @(negedge CLK);
    Trig_In = 1'b1;
    Ovr_Clr = 1'b1;
    @(negedge CLK);
    Trig_In = 1'b0;
    Ovr_Clr = 1'b0;
    check("ovr_set_beats_clear", Overrun, 1);
    wait_idle(200);
    check("ovr_frame_cnt", Frame_Cnt, 7);
    check("ovr_queue_empty", exp_q.size(), 0);
    Ovr_Clr = 1'b1;
    @(negedge CLK);
    Ovr_Clr = 1'b0;

    // Timeout when Tx_Done never comes
    never_done = 1'b1;
    Acc_Value = 24'h55AA55;
    exp_q.push_back(8'hA5);
    pulse_trig();
    @(negedge CLK);
    #1;
    check("to_start", Tx_Start, 1);
    repeat (7) @(negedge CLK);
    check("to_err_not_yet", Err, 0);
    repeat (2) @(negedge CLK);
    check("to_err_set", Err, 1);
    check("to_idle", Frame_Busy, 0);
    check("to_frame_cnt", Frame_Cnt, 7);
    never_done = 1'b0;
    repeat (4) @(negedge CLK);
    run_frame(24'h55AA55);
    check("to_recover_cnt", Frame_Cnt, 8);
    check("to_err_sticky", Err, 1);
    Ovr_Clr = 1'b1;
    @(negedge CLK);
    Ovr_Clr = 1'b0;
    check("to_err_clear", Err, 0);

    // Frame counter wrap
    dly = 1;
    for (int i = 0; i < 247; i++) run_frame(24'h000000);
    check("wrap_255", Frame_Cnt, 255);
    run_frame(24'h000000);
    check("wrap_0", Frame_Cnt, 0);
    run_frame(24'h000000);
    check("wrap_1", Frame_Cnt, 1);

    // Reset during byte 2
    dly = 3;
    Acc_Value = 24'h123456;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    pulse_trig();
    repeat (3) @(negedge CLK);
    pulse_trig();
    check("mid_overrun", Overrun, 1);
    repeat (7) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("mid_rst_tx_start", Tx_Start, 0);
    check("mid_rst_tx_data", Tx_Data, 0);
    check("mid_rst_busy", Frame_Busy, 0);
    check("mid_rst_cnt", Frame_Cnt, 0);
    check("mid_rst_overrun", Overrun, 0);
    check("mid_rst_err", Err, 0);
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (30) @(negedge CLK);
    check("post_rst_idle", Frame_Busy, 0);
    check("post_rst_queue", exp_q.size(), 0);
    run_frame(24'h123456);
    check("post_rst_frame", Frame_Cnt, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
